// File: rtl/ramreader_sched_pkg.sv
// ramreader_sched_pkg
// Shared types and constants for the RAMReader round-robin scheduler.
//   state_e      : scheduler FSM states
//   LINE_BYTES   : granule of every job length (low bits of NBYTES dropped)
//   BEAT_BYTES   : AXI beat width of the reader
//   RAM_BYTES    : capacity of the reader's line-buffer RAM (upper chunk limit)
//   line_floor() : rounds a byte count down to whole lines
package ramreader_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int LINE_BYTES = 128;
    localparam int BEAT_BYTES = 8;
    localparam int RAM_BYTES  = 512 * BEAT_BYTES;

    function automatic logic [31:0] line_floor(input logic [31:0] nbytes);
        return nbytes & ~32'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/ramreader_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick: the first requesting index at or after
// ptr_i, wrapping around. The pointer itself is owned by the parent.
//   req_i : request vector
//   ptr_i : index with highest priority this cycle
//   gnt_o : one-hot grant (all zero when nothing requests)
//   idx_o : binary index of the granted requester
//   any_o : at least one request present
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    always_comb begin
        int cand;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        // Walk priorities starting at the pointer; the inner loop turns the
        // rotated index back into a constant bit position.
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (cand == j) && req_i[j]) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IW'(j);
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/ramreader_sched.sv
// ramreader_sched
// Shares one RAMReader among NREQ requesters. Each accepted job is split into
// chunks of at most MAX_CHUNK bytes which are issued one at a time over the
// reader's VALID/READY control port; REQ_DONE pulses once the last chunk drains.
//   ACLK, ARESETN       : clock, asynchronous active-low reset
//   REQ_VALID/REQ_READY : per-requester job handshake (READY one-hot, 1 cycle)
//   REQ_ADDR/REQ_NBYTES : packed 32-bit start address / byte count per requester
//   REQ_DONE            : one-hot completion pulse
//   GRANT               : requester currently owning the reader
//   BUSY                : scheduler not idle
//   RD_VALID/RD_READY   : reader control handshake
//   RD_START_ADDR/RD_NBYTES : chunk descriptor driven while RD_VALID is high
module ramreader_sched
    import ramreader_sched_pkg::*;
#(
    parameter  int NREQ      = 2,
    parameter  int MAX_CHUNK = 4096,
    localparam int GW        = $clog2(NREQ)
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic [NREQ-1:0]     REQ_VALID,
    output logic [NREQ-1:0]     REQ_READY,
    input  logic [NREQ*32-1:0]  REQ_ADDR,
    input  logic [NREQ*32-1:0]  REQ_NBYTES,
    output logic [NREQ-1:0]     REQ_DONE,
    output logic [GW-1:0]       GRANT,
    output logic                BUSY,
    output logic                RD_VALID,
    input  logic                RD_READY,
    output logic [31:0]         RD_START_ADDR,
    output logic [31:0]         RD_NBYTES
);

    localparam logic [31:0] MAX_CHUNK_W = 32'(MAX_CHUNK);

    if ((MAX_CHUNK % LINE_BYTES) != 0 || MAX_CHUNK > RAM_BYTES || MAX_CHUNK < LINE_BYTES) begin : g_bad_chunk
        $error("ramreader_sched: MAX_CHUNK must be a multiple of 128 in 128..4096");
    end

    state_e        state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   rem_q, rem_d;

    logic [NREQ-1:0] arb_gnt;
    logic [GW-1:0]   arb_idx;
    logic            arb_any;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_nbytes;
    logic [31:0]     chunk;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (REQ_VALID),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // One-hot mux of the granted requester's job descriptor.
    always_comb begin
        sel_addr   = '0;
        sel_nbytes = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (arb_gnt[j]) begin
                sel_addr   = sel_addr   | REQ_ADDR[32*j +: 32];
                sel_nbytes = sel_nbytes | REQ_NBYTES[32*j +: 32];
            end
        end
    end

    assign chunk = (rem_q > MAX_CHUNK_W) ? MAX_CHUNK_W : rem_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    ptr_d   = (arb_idx == GW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    grant_d = arb_idx;
                    addr_d  = sel_addr;
                    rem_d   = line_floor(sel_nbytes);
                    // Sub-line jobs would hang the reader; finish them here.
                    state_d = (line_floor(sel_nbytes) == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (RD_READY) begin
                    addr_d  = addr_q + chunk;
                    rem_d   = rem_q - chunk;
                    state_d = ST_SETTLE;
                end
            end
            // The reader still shows READY the cycle after the handshake;
            // skipping it keeps that stale READY from ending WAIT early.
            ST_SETTLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (RD_READY) begin
                    state_d = (rem_q == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // REQ_READY is the only output that looks at inputs; it is forced low in
    // reset so every output reads zero while ARESETN is asserted.
    assign REQ_READY     = (state_q == ST_IDLE && ARESETN) ? arb_gnt : '0;
    assign GRANT         = grant_q;
    assign BUSY          = (state_q != ST_IDLE);
    assign RD_VALID      = (state_q == ST_ISSUE);
    assign RD_START_ADDR = (state_q == ST_ISSUE) ? addr_q : '0;
    assign RD_NBYTES     = (state_q == ST_ISSUE) ? chunk  : '0;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_done
        assign REQ_DONE[gi] = (state_q == ST_DONE) && (grant_q == GW'(gi));
    end

endmodule

// File: tb/tb_ramreader_sched.sv
module tb_ramreader_sched;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [1:0]  REQ_VALID = '0;
    logic [1:0]  REQ_READY;
    logic [63:0] REQ_ADDR = '0;
    logic [63:0] REQ_NBYTES = '0;
    logic [1:0]  REQ_DONE;
    logic [0:0]  GRANT;
    logic        BUSY;
    logic        RD_VALID;
    logic        RD_READY = 1'b0;
    logic [31:0] RD_START_ADDR;
    logic [31:0] RD_NBYTES;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ramreader_sched #(.NREQ(2), .MAX_CHUNK(4096)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .REQ_VALID     (REQ_VALID),
        .REQ_READY     (REQ_READY),
        .REQ_ADDR      (REQ_ADDR),
        .REQ_NBYTES    (REQ_NBYTES),
        .REQ_DONE      (REQ_DONE),
        .GRANT         (GRANT),
        .BUSY          (BUSY),
        .RD_VALID      (RD_VALID),
        .RD_READY      (RD_READY),
        .RD_START_ADDR (RD_START_ADDR),
        .RD_NBYTES     (RD_NBYTES)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Reader model + event logs. READY is high when idle, stays high for the
    // cycle after a handshake, then drops for busy_len cycles.
    int          busy_len = 3;
    int          ph = 0;
    int          cnt = 0;
    int          viol = 0;
    logic [31:0] ch_addr[$];
    logic [31:0] ch_nb[$];
    int          ch_cyc[$];
    int          ch_gnt[$];
    int          acc_idx[$];
    int          acc_cyc[$];
    int          done_idx[$];
    int          done_cyc[$];

    always @(negedge ACLK) begin
        #2;
        if (!ARESETN) begin
            ph = 0;
            RD_READY = 1'b0;
        end else begin
            case (ph)
                0: begin
                    RD_READY = 1'b1;
                    if (RD_VALID) begin
                        ch_addr.push_back(RD_START_ADDR);
                        ch_nb.push_back(RD_NBYTES);
                        ch_cyc.push_back(cyc);
                        ch_gnt.push_back(int'(GRANT));
                        $display("[%0d] chunk addr=%h nbytes=%0d grant=%0d", cyc, RD_START_ADDR, RD_NBYTES, GRANT);
                        ph = 1;
                    end
                end
                1: begin
                    RD_READY = 1'b1;
                    if (RD_VALID) viol++;
                    ph  = 2;
                    cnt = busy_len;
                end
                default: begin
                    RD_READY = 1'b0;
                    if (RD_VALID) viol++;
                    cnt--;
                    if (cnt <= 0) ph = 0;
                end
            endcase
            if (REQ_READY != 2'b00) begin
                acc_idx.push_back(REQ_READY[1] ? 1 : 0);
                acc_cyc.push_back(cyc);
                $display("[%0d] accept req=%0d", cyc, REQ_READY[1] ? 1 : 0);
            end
            if (REQ_DONE != 2'b00) begin
                done_idx.push_back(REQ_DONE[1] ? 1 : 0);
                done_cyc.push_back(cyc);
                $display("[%0d] done req=%0d", cyc, REQ_DONE[1] ? 1 : 0);
            end
        end
    end

    function automatic logic [31:0] qa(logic [31:0] q[$], int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int qi(int q[$], int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_logs();
        ch_addr.delete(); ch_nb.delete(); ch_cyc.delete(); ch_gnt.delete();
        acc_idx.delete(); acc_cyc.delete(); done_idx.delete(); done_cyc.delete();
        viol = 0;
    endtask

    // Offer a job on requester i starting at a negedge; drop it after acceptance
    // and scribble the inputs to show the scheduler latched them.
    task automatic offer(input int i, input logic [31:0] a, input logic [31:0] n, output bit ok);
        REQ_ADDR[32*i +: 32]   = a;
        REQ_NBYTES[32*i +: 32] = n;
        REQ_VALID[i] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #3;
            if (REQ_READY[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        @(negedge ACLK);
        REQ_VALID[i] = 1'b0;
        REQ_ADDR[32*i +: 32]   = 32'hDEAD_BEEF;
        REQ_NBYTES[32*i +: 32] = 32'h0000_3F80;
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (done_idx.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge ACLK);
        end
        repeat (3) @(negedge ACLK);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ACLK);
        #1;
        total++; if (REQ_READY !== 2'b00) begin bad++; $display("FAIL reset_req_ready: got %b want 00", REQ_READY); end
        total++; if (REQ_DONE !== 2'b00) begin bad++; $display("FAIL reset_req_done: got %b want 00", REQ_DONE); end
        total++; if (GRANT !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b want 0", GRANT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        total++; if (RD_VALID !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", RD_VALID); end
        total++; if (RD_START_ADDR !== 32'h0) begin bad++; $display("FAIL reset_rd_addr: got %h want 0", RD_START_ADDR); end
        total++; if (RD_NBYTES !== 32'h0) begin bad++; $display("FAIL reset_rd_nbytes: got %h want 0", RD_NBYTES); end
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b want 0", BUSY); end
        $display("[%0d] reset checked", cyc);
    endtask

    task automatic run_both();
        logic [1:0] rdy;
        REQ_ADDR   = {32'h0000_0200, 32'h0000_0100};
        REQ_NBYTES = {32'd128, 32'd128};
        REQ_VALID  = 2'b11;
        for (int k = 0; k < 300 && REQ_VALID != 2'b00; k++) begin
            #3;
            rdy = REQ_READY;
            @(negedge ACLK);
            REQ_VALID = REQ_VALID & ~rdy;
        end
        REQ_VALID = 2'b00;
    endtask

    task automatic test_round_robin();
        bit ok;
        clear_logs();
        busy_len = 2;
        run_both();
        wait_done(2, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr1_done: got %0d dones want 2", done_idx.size()); end
        total++; if (qi(acc_idx, 0) != 0 || qi(acc_idx, 1) != 1) begin bad++; $display("FAIL rr1_order: got %0d,%0d want 0,1", qi(acc_idx, 0), qi(acc_idx, 1)); end
        total++; if (qa(ch_addr, 0) !== 32'h100 || qa(ch_addr, 1) !== 32'h200) begin bad++; $display("FAIL rr1_addr: got %h,%h want 100,200", qa(ch_addr, 0), qa(ch_addr, 1)); end
        total++; if (qa(ch_nb, 0) !== 32'd128 || qa(ch_nb, 1) !== 32'd128) begin bad++; $display("FAIL rr1_nbytes: got %0d,%0d want 128,128", qa(ch_nb, 0), qa(ch_nb, 1)); end
        total++; if (qi(ch_gnt, 0) != 0 || qi(ch_gnt, 1) != 1) begin bad++; $display("FAIL rr1_grant: got %0d,%0d want 0,1", qi(ch_gnt, 0), qi(ch_gnt, 1)); end
        total++; if (qi(done_idx, 0) != 0 || qi(done_idx, 1) != 1) begin bad++; $display("FAIL rr1_done_order: got %0d,%0d want 0,1", qi(done_idx, 0), qi(done_idx, 1)); end
        total++; if (qi(acc_cyc, 1) - qi(done_cyc, 0) != 1) begin bad++; $display("FAIL rr1_done_to_accept: got %0d want 1", qi(acc_cyc, 1) - qi(done_cyc, 0)); end
        clear_logs();
        run_both();
        wait_done(2, ok);
        total++; if (qi(acc_idx, 0) != 0 || qi(acc_idx, 1) != 1) begin bad++; $display("FAIL rr2_order: got %0d,%0d want 0,1", qi(acc_idx, 0), qi(acc_idx, 1)); end
        busy_len = 3;
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        offer(0, 32'h0000_1000, 32'd256, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_accept: got no REQ_READY want accept"); end
        wait_done(1, ok);
        total++; if (ch_addr.size() != 1) begin bad++; $display("FAIL single_chunks: got %0d want 1", ch_addr.size()); end
        total++; if (qa(ch_addr, 0) !== 32'h1000) begin bad++; $display("FAIL single_addr: got %h want 00001000", qa(ch_addr, 0)); end
        total++; if (qa(ch_nb, 0) !== 32'd256) begin bad++; $display("FAIL single_nbytes: got %0d want 256", qa(ch_nb, 0)); end
        total++; if (qi(ch_cyc, 0) - qi(acc_cyc, 0) != 1) begin bad++; $display("FAIL single_issue_latency: got %0d want 1", qi(ch_cyc, 0) - qi(acc_cyc, 0)); end
        total++; if (qi(done_cyc, 0) - qi(ch_cyc, 0) != busy_len + 3) begin bad++; $display("FAIL single_done_latency: got %0d want %0d", qi(done_cyc, 0) - qi(ch_cyc, 0), busy_len + 3); end
        total++; if (done_idx.size() != 1 || qi(done_idx, 0) != 0) begin bad++; $display("FAIL single_done: got n=%0d idx=%0d want n=1 idx=0", done_idx.size(), qi(done_idx, 0)); end
    endtask

    task automatic test_multi_chunk();
        bit ok;
        clear_logs();
        offer(1, 32'h0000_2000, 32'd10000, ok);
        wait_done(1, ok);
        total++; if (ch_addr.size() != 3) begin bad++; $display("FAIL multi_chunks: got %0d want 3", ch_addr.size()); end
        total++; if (qa(ch_addr, 0) !== 32'h2000 || qa(ch_addr, 1) !== 32'h3000 || qa(ch_addr, 2) !== 32'h4000)
            begin bad++; $display("FAIL multi_addr: got %h,%h,%h want 2000,3000,4000", qa(ch_addr, 0), qa(ch_addr, 1), qa(ch_addr, 2)); end
        total++; if (qa(ch_nb, 0) !== 32'd4096 || qa(ch_nb, 1) !== 32'd4096 || qa(ch_nb, 2) !== 32'd1792)
            begin bad++; $display("FAIL multi_nbytes: got %0d,%0d,%0d want 4096,4096,1792", qa(ch_nb, 0), qa(ch_nb, 1), qa(ch_nb, 2)); end
        total++; if (qi(ch_cyc, 1) - qi(ch_cyc, 0) != busy_len + 3) begin bad++; $display("FAIL multi_spacing: got %0d want %0d", qi(ch_cyc, 1) - qi(ch_cyc, 0), busy_len + 3); end
        total++; if (qi(ch_gnt, 0) != 1 || qi(ch_gnt, 2) != 1) begin bad++; $display("FAIL multi_grant: got %0d,%0d want 1,1", qi(ch_gnt, 0), qi(ch_gnt, 2)); end
        total++; if (done_idx.size() != 1 || qi(done_idx, 0) != 1) begin bad++; $display("FAIL multi_done: got n=%0d idx=%0d want n=1 idx=1", done_idx.size(), qi(done_idx, 0)); end
    endtask

    task automatic test_short_jobs();
        bit ok;
        clear_logs();
        offer(0, 32'h0000_5000, 32'd100, ok);
        wait_done(1, ok);
        offer(1, 32'h0000_5800, 32'd0, ok);
        wait_done(2, ok);
        total++; if (ch_addr.size() != 0) begin bad++; $display("FAIL short_no_rd_valid: got %0d chunks want 0", ch_addr.size()); end
        total++; if (qi(done_cyc, 0) - qi(acc_cyc, 0) != 1) begin bad++; $display("FAIL short_done_latency: got %0d want 1", qi(done_cyc, 0) - qi(acc_cyc, 0)); end
        total++; if (qi(done_idx, 0) != 0 || qi(done_idx, 1) != 1) begin bad++; $display("FAIL short_done_idx: got %0d,%0d want 0,1", qi(done_idx, 0), qi(done_idx, 1)); end
        clear_logs();
        offer(0, 32'h0000_6000, 32'd300, ok);
        wait_done(1, ok);
        total++; if (ch_addr.size() != 1 || qa(ch_nb, 0) !== 32'd256 || qa(ch_addr, 0) !== 32'h6000)
            begin bad++; $display("FAIL trunc_300: got n=%0d nbytes=%0d addr=%h want n=1 nbytes=256 addr=00006000", ch_addr.size(), qa(ch_nb, 0), qa(ch_addr, 0)); end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        clear_logs();
        offer(1, 32'hFFFF_F000, 32'd8192, ok);
        wait_done(1, ok);
        total++; if (qa(ch_addr, 0) !== 32'hFFFF_F000 || qa(ch_addr, 1) !== 32'h0000_0000 || ch_addr.size() != 2)
            begin bad++; $display("FAIL wrap_addr: got n=%0d %h,%h want n=2 fffff000,00000000", ch_addr.size(), qa(ch_addr, 0), qa(ch_addr, 1)); end
    endtask

    task automatic test_ready_hold();
        bit ok;
        clear_logs();
        busy_len = 8;
        offer(0, 32'h0000_7000, 32'd4352, ok);
        wait_done(1, ok);
        total++; if (viol != 0) begin bad++; $display("FAIL hold_early_valid: got %0d early RD_VALID want 0", viol); end
        total++; if (qi(ch_cyc, 1) - qi(ch_cyc, 0) != 11) begin bad++; $display("FAIL hold_spacing: got %0d want 11", qi(ch_cyc, 1) - qi(ch_cyc, 0)); end
        total++; if (qa(ch_addr, 1) !== 32'h8000 || qa(ch_nb, 1) !== 32'd256) begin bad++; $display("FAIL hold_chunk2: got %h/%0d want 00008000/256", qa(ch_addr, 1), qa(ch_nb, 1)); end
        busy_len = 3;
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        busy_len = 6;
        offer(1, 32'h0000_A000, 32'd12288, ok);
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (ch_addr.size() >= 2) begin ok = 1'b1; break; end
            @(negedge ACLK);
        end
        total++; if (!ok) begin bad++; $display("FAIL midrst_reach_chunk2: got %0d chunks want 2", ch_addr.size()); end
        @(negedge ACLK);
        #3;
        total++; if (BUSY !== 1'b1 || GRANT !== 1'b1) begin bad++; $display("FAIL midrst_pre: got busy=%b grant=%b want 1,1", BUSY, GRANT); end
        ARESETN = 1'b0;
        #1;
        total++; if (BUSY !== 1'b0 || GRANT !== 1'b0 || RD_VALID !== 1'b0 || REQ_DONE !== 2'b00 || REQ_READY !== 2'b00)
            begin bad++; $display("FAIL midrst_outputs: got busy=%b grant=%b rdv=%b done=%b rdy=%b want all 0", BUSY, GRANT, RD_VALID, REQ_DONE, REQ_READY); end
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (12) @(negedge ACLK);
        total++; if (done_idx.size() != 0 || ch_addr.size() != 2) begin bad++; $display("FAIL midrst_abort: got dones=%0d chunks=%0d want 0,2", done_idx.size(), ch_addr.size()); end
        offer(0, 32'h0000_9000, 32'd256, ok);
        wait_done(1, ok);
        total++; if (qa(ch_addr, 2) !== 32'h9000 || qa(ch_nb, 2) !== 32'd256 || qi(done_idx, 0) != 0)
            begin bad++; $display("FAIL midrst_fresh: got %h/%0d done=%0d want 00009000/256 done=0", qa(ch_addr, 2), qa(ch_nb, 2), qi(done_idx, 0)); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_multi_chunk();
        test_short_jobs();
        test_addr_wrap();
        test_ready_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
